// File: rtl/psg_pkg.sv
// Shared types and constants for the stereo PSG: write-FSM states, register
// types, noise rate codes and the 2 dB attenuation table.
package psg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wr_state_t;

    typedef enum logic {
        TYPE_TONE = 1'b0,
        TYPE_VOL  = 1'b1
    } reg_type_t;

    localparam logic [1:0] NOISE_RATE_16    = 2'd0;
    localparam logic [1:0] NOISE_RATE_32    = 2'd1;
    localparam logic [1:0] NOISE_RATE_64    = 2'd2;
    localparam logic [1:0] NOISE_RATE_TONE2 = 2'd3;

    // Index 0 is loudest; entry 15 is silence.
    localparam logic [15:0][7:0] ATTEN_LUT = {
        8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
        8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
    };

    function automatic logic [9:0] noise_period(input logic [1:0] rate);
        case (rate)
            NOISE_RATE_16: return 10'd16;
            NOISE_RATE_32: return 10'd32;
            NOISE_RATE_64: return 10'd64;
            default:       return 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/psg_tone_gen.sv
// Half-period divider: counts voice ticks down from the period and flips its
// toggle on every reload. The period is sampled only when reloading.
module psg_tone_gen (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       tick,
    input  logic [9:0] period,
    output logic       tgl
);

    logic [9:0] cnt_q;

    // Reload on the tick that would take the count to zero, so a period P
    // gives exactly P ticks between toggles.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
            tgl   <= 1'b0;
        end else if (tick) begin
            if (cnt_q <= 10'd1) begin
                cnt_q <= period;
                tgl   <= ~tgl;
            end else begin
                cnt_q <= cnt_q - 10'd1;
            end
        end
    end

endmodule

// File: rtl/psg_stereo_core.sv
// SN76489-class sound generator: byte-bus register file with READY wait
// states, three tone voices, LFSR noise, per-voice panning and two PWM DACs.
module psg_stereo_core
    import psg_pkg::*;
#(
    parameter int                CLK_DIV     = 16,
    parameter int                LFSR_W      = 15,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = LFSR_W'(3),
    parameter int                PWM_W       = 8,
    parameter int                WAIT_CYCLES = 32
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      nCE,
    input  logic      nWE,
    input  logic      PAN_SEL,
    input  logic [7:0] D,
    output logic      READY,
    output logic      AOUT_L,
    output logic      AOUT_R,
    output logic      SAMPLE_STB,
    output wr_state_t dbg_wr_state
);

    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int WCW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0]    WAIT_LAST = WCW'(WAIT_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [LFSR_W-1:0] LFSR_SEED = {1'b1, {(LFSR_W-1){1'b0}}};

    wr_state_t         state_q;
    logic [WCW-1:0]    wait_cnt_q;
    logic              strobe;
    logic              accept;
    logic              noise_wr;

    logic [2:0][9:0]   tone_q;
    logic [3:0][3:0]   vol_q;
    logic [2:0]        noise_q;
    logic [7:0]        pan_q;
    logic [1:0]        ch_q;
    reg_type_t         type_q;

    logic [PRE_W-1:0]  pre_cnt_q;
    logic              tick;
    logic [2:0]        tone_tgl;
    logic              noise_div_tgl;
    logic              noise_tgl;
    logic              noise_tgl_q;
    logic              noise_shift;
    logic              lfsr_msb_in;
    logic [LFSR_W-1:0] lfsr_q;
    logic [3:0]        voice_out;

    logic [9:0]        sum_l;
    logic [9:0]        sum_r;
    logic [PWM_W-1:0]  level_l_q;
    logic [PWM_W-1:0]  level_r_q;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic [PWM_W-1:0]  lat_l_q;
    logic [PWM_W-1:0]  lat_r_q;
    logic              stb_q;

    // Bus handshake: a write is accepted only in IDLE when nCE and nWE are both
    // low; READY stays low for WAIT_CYCLES cycles and until the strobe is released.
    assign strobe       = !nCE && !nWE;
    assign accept       = (state_q == IDLE) && strobe;
    assign READY        = (state_q == IDLE);
    assign dbg_wr_state = state_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        if (!strobe) state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        noise_wr = 1'b0;
        if (accept && !PAN_SEL) begin
            if (D[7]) noise_wr = !D[4] && (D[6:5] == 2'd3);
            else      noise_wr = (type_q == TYPE_TONE) && (ch_q == 2'd3);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            tone_q  <= '0;
            vol_q   <= {4{4'hF}};
            noise_q <= '0;
            pan_q   <= 8'hFF;
            ch_q    <= '0;
            type_q  <= TYPE_TONE;
        end else if (accept) begin
            if (PAN_SEL) begin
                pan_q <= D;
            end else if (D[7]) begin
                ch_q   <= D[6:5];
                type_q <= reg_type_t'(D[4]);
                for (int i = 0; i < 4; i++)
                    if (D[4] && D[6:5] == 2'(i)) vol_q[i] <= D[3:0];
                for (int i = 0; i < 3; i++)
                    if (!D[4] && D[6:5] == 2'(i)) tone_q[i][3:0] <= D[3:0];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (type_q == TYPE_VOL && ch_q == 2'(i)) vol_q[i] <= D[3:0];
                for (int i = 0; i < 3; i++)
                    if (type_q == TYPE_TONE && ch_q == 2'(i)) tone_q[i][9:4] <= D[5:0];
            end
            if (noise_wr) noise_q <= D[2:0];
        end
    end

    assign tick = (pre_cnt_q == PRE_LAST);

    always_ff @(posedge CLK) begin
        if (!nRST) pre_cnt_q <= '0;
        else       pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : gen_tone
        psg_tone_gen u_tone (
            .CLK    (CLK),
            .nRST   (nRST),
            .tick   (tick),
            .period (tone_q[g]),
            .tgl    (tone_tgl[g])
        );
    end

    psg_tone_gen u_noise_div (
        .CLK    (CLK),
        .nRST   (nRST),
        .tick   (tick),
        .period (noise_period(noise_q[1:0])),
        .tgl    (noise_div_tgl)
    );

    // Rate 3 slaves the noise clock to voice 2: it flips whenever tone 2 reloads.
    assign noise_tgl   = (noise_q[1:0] == NOISE_RATE_TONE2) ? tone_tgl[2] : noise_div_tgl;
    assign noise_shift = noise_tgl && !noise_tgl_q;
    assign lfsr_msb_in = noise_q[2] ? ^(lfsr_q & LFSR_TAPS) : lfsr_q[0];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            noise_tgl_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            noise_tgl_q <= noise_tgl;
            if (noise_wr)         lfsr_q <= LFSR_SEED;
            else if (noise_shift) lfsr_q <= {lfsr_msb_in, lfsr_q[LFSR_W-1:1]};
        end
    end

    always_comb begin
        voice_out = '0;
        for (int n = 0; n < 3; n++)
            voice_out[n] = (tone_q[n] <= 10'd1) ? 1'b1 : tone_tgl[n];
        voice_out[3] = lfsr_q[0];
    end

    // Four 8-bit amplitudes peak at 1020, so a 10-bit sum never wraps.
    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int n = 0; n < 4; n++) begin
            if (voice_out[n] && pan_q[n+4]) sum_l = sum_l + {2'b00, ATTEN_LUT[vol_q[n]]};
            if (voice_out[n] && pan_q[n])   sum_r = sum_r + {2'b00, ATTEN_LUT[vol_q[n]]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            level_l_q <= '0;
            level_r_q <= '0;
            pwm_cnt_q <= '0;
            lat_l_q   <= '0;
            lat_r_q   <= '0;
            stb_q     <= 1'b0;
        end else begin
            level_l_q <= sum_l[9 -: PWM_W];
            level_r_q <= sum_r[9 -: PWM_W];
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            stb_q     <= (pwm_cnt_q == '0);
            if (pwm_cnt_q == '0) begin
                lat_l_q <= level_l_q;
                lat_r_q <= level_r_q;
            end
        end
    end

    assign AOUT_L     = (pwm_cnt_q < lat_l_q);
    assign AOUT_R     = (pwm_cnt_q < lat_r_q);
    assign SAMPLE_STB = stb_q;

endmodule

// File: tb/tb_psg_stereo_core.sv
// Directed bench for psg_stereo_core: register writes, READY timing, tone
// periods, PWM duty per pan/volume, noise LFSR sequence and reset recovery.
module tb_psg_stereo_core;
    import psg_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      nCE;
    logic      nWE;
    logic      PAN_SEL;
    logic [7:0] D;
    logic      READY;
    logic      AOUT_L;
    logic      AOUT_R;
    logic      SAMPLE_STB;
    wr_state_t dbg_wr_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          t0_q[$];
    int          t1_q[$];
    logic [14:0] lv_q[$];
    int          lt_q[$];
    logic [14:0] exp_q[$];
    logic        v0_prev = 1'b1;
    logic        v1_prev = 1'b1;
    logic [14:0] lfsr_prev = 15'h4000;
    logic [14:0] wr_lfsr_snap;

    psg_stereo_core dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .nCE          (nCE),
        .nWE          (nWE),
        .PAN_SEL      (PAN_SEL),
        .D            (D),
        .READY        (READY),
        .AOUT_L       (AOUT_L),
        .AOUT_R       (AOUT_R),
        .SAMPLE_STB   (SAMPLE_STB),
        .dbg_wr_state (dbg_wr_state)
    );

    // Clock and cycle counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitors: tone edges at the negedge, LFSR changes 2 ns after posedge
    always @(negedge CLK) begin
        if (dut.voice_out[0] !== v0_prev) t0_q.push_back(cyc);
        if (dut.voice_out[1] !== v1_prev) t1_q.push_back(cyc);
        v0_prev = dut.voice_out[0];
        v1_prev = dut.voice_out[1];
    end

    always @(posedge CLK) begin
        #2;
        if (dut.lfsr_q !== lfsr_prev) begin
            lv_q.push_back(dut.lfsr_q);
            lt_q.push_back(cyc);
        end
        lfsr_prev = dut.lfsr_q;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver: one-cycle strobe, returns the number of cycles READY stayed low
    task automatic psg_write(input logic pan, input logic [7:0] d, output int low_cycles);
        @(negedge CLK);
        PAN_SEL = pan;
        D       = d;
        nCE     = 1'b0;
        nWE     = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nCE = 1'b1;
        nWE = 1'b1;
        wr_lfsr_snap = dut.lfsr_q;
        lv_q.delete();
        lt_q.delete();
        low_cycles = 0;
        while (!READY && low_cycles < 200) begin
            low_cycles++;
            @(negedge CLK);
        end
    endtask

    // Syncs to a rising edge of voice 0, then counts PWM high cycles over one full period
    task automatic measure_duty(input string tag, output int hl, output int hr, output int gap);
        int n;
        hl = 0;
        hr = 0;
        gap = 0;
        n = 0;
        while (dut.voice_out[0] !== 1'b0 && n < 10000) begin @(negedge CLK); n++; end
        while (dut.voice_out[0] !== 1'b1 && n < 10000) begin @(negedge CLK); n++; end
        check_eq({tag, "_sync"}, 32'(n < 10000), 32'd1);
        n = 0;
        while (!SAMPLE_STB && n < 300) begin @(negedge CLK); n++; end
        do begin @(negedge CLK); gap++; end while (!SAMPLE_STB && gap < 300);
        for (int i = 0; i < 256; i++) begin
            hl += int'(AOUT_L);
            hr += int'(AOUT_R);
            @(negedge CLK);
        end
    endtask

    initial begin
        int low;
        int hl, hr, gap, n;
        logic [14:0] m;

        nRST = 1'b0; nCE = 1'b1; nWE = 1'b1; PAN_SEL = 1'b0; D = 8'h00;
        repeat (3) @(negedge CLK);
        check_eq("rst_ready", 32'(READY), 32'd1);
        check_eq("rst_state", 32'(dbg_wr_state), 32'(IDLE));
        check_eq("rst_aout", {30'd0, AOUT_L, AOUT_R}, 32'd0);
        check_eq("rst_stb", 32'(SAMPLE_STB), 32'd0);
        check_eq("rst_lfsr", 32'(dut.lfsr_q), 32'h4000);
        check_eq("rst_pan", 32'(dut.pan_q), 32'hFF);
        check_eq("rst_vol", 32'(dut.vol_q), 32'hFFFF);
        check_eq("rst_tone", 32'(dut.tone_q), 32'd0);
        nRST = 1'b1;

        // 1: tone0 = 0x0FE, vol0 = 0
        psg_write(1'b0, 8'h8E, low);
        check_eq("t1_ready_low_a", 32'(low), 32'd32);
        psg_write(1'b0, 8'h0F, low);
        check_eq("t1_ready_low_b", 32'(low), 32'd32);
        check_eq("t1_tone0", 32'(dut.tone_q[0]), 32'h0FE);
        psg_write(1'b0, 8'h90, low);
        check_eq("t1_vol0", 32'(dut.vol_q[0]), 32'h0);
        t0_q.delete();
        n = 0;
        while (t0_q.size() < 2 && n < 10000) begin @(negedge CLK); n++; end
        check_eq("t1_tone0_events", 32'(t0_q.size() >= 2), 32'd1);
        if (t0_q.size() >= 2) check_eq("t1_tone0_half", 32'(t0_q[1] - t0_q[0]), 32'd4064);

        // 2: pan 0x10 -> left only at full volume
        psg_write(1'b1, 8'h10, low);
        measure_duty("t2a", hl, hr, gap);
        check_eq("t2a_stb_gap", 32'(gap), 32'd256);
        check_eq("t2a_duty_l", 32'(hl), 32'd63);
        check_eq("t2a_duty_r", 32'(hr), 32'd0);
        psg_write(1'b1, 8'h01, low);
        psg_write(1'b0, 8'h94, low);
        measure_duty("t2b", hl, hr, gap);
        check_eq("t2b_duty_l", 32'(hl), 32'd0);
        check_eq("t2b_duty_r", 32'(hr), 32'd25);
        psg_write(1'b1, 8'h11, low);
        psg_write(1'b0, 8'h92, low);
        measure_duty("t2c", hl, hr, gap);
        check_eq("t2c_duty_l", 32'(hl), 32'd40);
        check_eq("t2c_duty_r", 32'(hr), 32'd40);

        // 3: white noise, rate 16, reseed and sequence against a bench model
        psg_write(1'b0, 8'hE4, low);
        check_eq("t3_reseed", 32'(wr_lfsr_snap), 32'h4000);
        check_eq("t3_noise_reg", 32'(dut.noise_q), 32'h4);
        m = 15'h4000;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            m = {^(m & 15'h0003), m[14:1]};
            exp_q.push_back(m);
        end
        psg_write(1'b0, 8'hF0, low);
        n = 0;
        while (lv_q.size() < 16 && n < 12000) begin @(negedge CLK); n++; end
        check_eq("t3_lfsr_events", 32'(lv_q.size() >= 16), 32'd1);
        if (lv_q.size() >= 16) begin
            check_eq("t3_shift_gap", 32'(lt_q[2] - lt_q[1]), 32'd512);
            for (int i = 0; i < 16; i++)
                check_eq($sformatf("t3_lfsr_%0d", i), 32'(lv_q[i]), 32'(exp_q[i]));
        end

        // 4: held strobe and a second pulse during WAIT are both ignored
        @(negedge CLK);
        PAN_SEL = 1'b0; D = 8'hD5; nCE = 1'b0; nWE = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("t4_state_wait", 32'(dbg_wr_state), 32'(WAIT));
        D = 8'hDA;
        repeat (39) @(negedge CLK);
        check_eq("t4_ready_held", 32'(READY), 32'd0);
        check_eq("t4_vol2_held", 32'(dut.vol_q[2]), 32'h5);
        nCE = 1'b1; nWE = 1'b1;
        @(negedge CLK);
        check_eq("t4_ready_release", 32'(READY), 32'd1);
        @(negedge CLK);
        D = 8'hD7; nCE = 1'b0; nWE = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nCE = 1'b1; nWE = 1'b1;
        low = 1;
        repeat (5) begin @(negedge CLK); low++; end
        D = 8'hD9; nCE = 1'b0; nWE = 1'b0;
        @(negedge CLK); low++;
        nCE = 1'b1; nWE = 1'b1;
        while (!READY && low < 200) begin @(negedge CLK); low++; end
        check_eq("t4_ready_low", 32'(low), 32'd33);
        check_eq("t4_vol2_pulse", 32'(dut.vol_q[2]), 32'h7);

        // 5: tone1 rewrite mid-count takes effect at the next reload
        psg_write(1'b0, 8'hA0, low);
        psg_write(1'b0, 8'h20, low);
        check_eq("t5_tone1_a", 32'(dut.tone_q[1]), 32'h200);
        t1_q.delete();
        n = 0;
        while (t1_q.size() < 2 && n < 20000) begin @(negedge CLK); n++; end
        psg_write(1'b0, 8'hA0, low);
        psg_write(1'b0, 8'h01, low);
        check_eq("t5_tone1_b", 32'(dut.tone_q[1]), 32'h010);
        n = 0;
        while (t1_q.size() < 4 && n < 20000) begin @(negedge CLK); n++; end
        check_eq("t5_tone1_events", 32'(t1_q.size() >= 4), 32'd1);
        if (t1_q.size() >= 4) begin
            check_eq("t5_half_old_a", 32'(t1_q[1] - t1_q[0]), 32'd8192);
            check_eq("t5_half_old_b", 32'(t1_q[2] - t1_q[1]), 32'd8192);
            check_eq("t5_half_new", 32'(t1_q[3] - t1_q[2]), 32'd256);
        end

        // 6: reset in the middle of a wait state
        @(negedge CLK);
        D = 8'h9A; nCE = 1'b0; nWE = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nCE = 1'b1; nWE = 1'b1;
        repeat (5) @(negedge CLK);
        check_eq("t6_ready_before", 32'(READY), 32'd0);
        nRST = 1'b0;
        @(negedge CLK);
        check_eq("t6_ready", 32'(READY), 32'd1);
        check_eq("t6_state", 32'(dbg_wr_state), 32'(IDLE));
        check_eq("t6_vol", 32'(dut.vol_q), 32'hFFFF);
        check_eq("t6_pan", 32'(dut.pan_q), 32'hFF);
        check_eq("t6_aout", {30'd0, AOUT_L, AOUT_R}, 32'd0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
